mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one synchronous data-memory port between two masters: the core (m0) and a loader/debug master (m1).
//  Arbitrates round-robin each cycle, forwards the winner's access to memory, and routes read data back
//  RD_LAT cycles later. It sits between core mem_addr/mem_data/mem_we and the data RAM. Reads are pipelined.
// PARAMETERS
//  ADDR_W  32  address width of masters and memory
//  DATA_W  32  data width
//  RD_LAT  1   memory read latency in cycles, from mem_re to valid mem_rdata (legal range 1..4)
// PORTS
//  clk        in   1       single clock; all state updates on posedge
//  rst        in   1       synchronous reset, active-high
//  m0_req     in   1       master 0 access request (held until granted)
//  m0_we      in   1       1 = write, 0 = read
//  m0_addr    in   ADDR_W  master 0 address
//  m0_wdata   in   DATA_W  master 0 write data
//  m0_gnt     out  1       combinational accept; req & gnt = transfer this cycle
//  m0_rvalid  out  1       one-cycle pulse: m0_rdata holds read data
//  m0_rdata   out  DATA_W  read data for master 0
//  m1_*       same set as m0_* for master 1
//  mem_addr   out  ADDR_W  address to RAM
//  mem_wdata  out  DATA_W  write data to RAM
//  mem_we     out  1       RAM write strobe
//  mem_re     out  1       RAM read strobe
//  mem_rdata  in   DATA_W  RAM read data, valid RD_LAT cycles after mem_re
// BEHAVIOUR
//  - Reset: last_gnt = m1, so m0 wins the first tie. Tag pipeline cleared. m*_gnt, m*_rvalid, mem_we, mem_re = 0
//    while rst is high. Reads in flight at reset are discarded, with no rvalid afterwards.
//  - Arbitration is combinational in the request cycle:
//    - only one master requests -> that master is granted, whatever last_gnt holds.
//    - both request -> grant the master other than last_gnt.
//    - neither requests -> no grant, last_gnt unchanged.
//  - last_gnt <= granted id on every grant, including single-requester grants.
//  - At most one gnt is high per cycle. Throughput is 1 access per cycle; no bubbles between back-to-back accesses.
//  - Memory outputs are muxed from the selected master: the granted one, or m0 when idle.
//    - mem_we = grant & we.
//    - mem_re = grant & ~we.
//  - Writes complete in the grant cycle. No response is generated for writes.
//  - Reads: a tag shift register of depth RD_LAT carries {valid, id} per stage.
//    - Stage 0 is loaded with {mem_re, gnt_id} on every clock.
//    - When the last stage is valid, m[id]_rvalid = 1 for exactly one cycle. m[id]_rdata = mem_rdata is
//      driven combinationally from the last stage; the other master's rvalid stays 0.
//    - Read responses return in issue order. Each master gets exactly one rvalid per granted read.
//  - m*_rdata is mem_rdata on both outputs at all times; it is meaningful only while rvalid is high.
//  - Requests may change while not granted; no stability rule applies before the grant.
//  - A master is never starved: with both requesting continuously, grants alternate m0, m1, m0, ...
//  - Simultaneous read return plus new grant in the same cycle is legal; the pipeline shifts and loads at once.
//  - RD_LAT outside 1..4: elaboration error via a generate-time check.
// STRUCTURE
//  - Shared package/header mem_arb_defs: MID_W = 1, constants MID_M0 = 0 and MID_M1 = 1, RD_LAT_MAX = 4.
//  - Sub-module rr_arb2: 2-way round-robin picker. Inputs req[1:0] and last_gnt; outputs gnt[1:0] and gnt_id.
//    Purely combinational; last_gnt is held by the parent.
//  - The parent holds last_gnt, the tag pipeline, the memory mux and the response demux.
// TESTING
//  1. After reset, m0 and m1 both request reads at addr 0x10 and 0x20 -> m0 granted in cycle 0, m1 in cycle 1;
//     with RD_LAT=1, m0_rvalid in cycle 1, m1_rvalid in cycle 2, each carrying RAM[addr].
//  2. Both hold req for 6 cycles -> gnt sequence m0,m1,m0,m1,m0,m1; never both gnt; mem_re high every cycle.
//  3. Only m1 requests a write of 0xDEADBEEF to 0x40 -> m1_gnt in the same cycle, mem_we=1, mem_addr=0x40,
//     no rvalid; a later m0 read of 0x40 returns 0xDEADBEEF.
//  4. RD_LAT=3, alternating reads m0,m1,m0 -> rvalid pulses 3 cycles after each grant, ids in order m0,m1,m0.
//  5. rst asserted one cycle after an m1 read grant (RD_LAT=2) -> no m1_rvalid ever appears;
//     outputs are 0 during reset; first tie after reset goes to m0.
//  6. No requests for 10 cycles -> mem_we=mem_re=0, all gnt and rvalid low, last_gnt unchanged.

Source files
------------

// File: rtl/mem_arb_defs.sv
// Shared master ids and limits for the two-master memory arbiter.
package mem_arb_defs;
  localparam int MID_W      = 1;
  localparam int RD_LAT_MAX = 4;

  localparam logic [MID_W-1:0] MID_M0 = 1'b0;
  localparam logic [MID_W-1:0] MID_M1 = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; purely combinational, the parent owns last_gnt.
module rr_arb2
  import mem_arb_defs::*;
(
  input  logic [1:0]       req,
  input  logic [MID_W-1:0] last_gnt,
  output logic [1:0]       gnt,
  output logic [MID_W-1:0] gnt_id
);

  always_comb begin
    gnt    = 2'b00;
    gnt_id = MID_M0;
    if (req == 2'b11) begin
      // On a tie the master that did not win last time goes first.
      if (last_gnt == MID_M1) begin
        gnt    = 2'b01;
        gnt_id = MID_M0;
      end else begin
        gnt    = 2'b10;
        gnt_id = MID_M1;
      end
    end else if (req[0]) begin
      gnt    = 2'b01;
      gnt_id = MID_M0;
    end else if (req[1]) begin
      gnt    = 2'b10;
      gnt_id = MID_M1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous RAM port between two masters, round-robin per cycle,
// with a tag pipeline that steers read data back to the issuing master.
module mem_arbiter
  import mem_arb_defs::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  generate
    if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
      $error("mem_arbiter: RD_LAT must be in 1..4");
    end
  endgenerate

  logic [1:0]       w_req;
  logic [1:0]       w_arb_gnt;
  logic [MID_W-1:0] w_arb_id;
  logic [1:0]       w_gnt;
  logic             w_any_gnt;
  logic             w_sel_m1;
  logic             w_we;
  logic [MID_W-1:0] r_last_gnt;

  assign w_req = {m1_req, m0_req};

  rr_arb2 u_arb (
    .req      (w_req),
    .last_gnt (r_last_gnt),
    .gnt      (w_arb_gnt),
    .gnt_id   (w_arb_id)
  );

  // Reset masks every grant so nothing reaches the RAM while rst is high.
  assign w_gnt     = w_arb_gnt & {2{~rst}};
  assign w_any_gnt = |w_gnt;
  assign w_sel_m1  = w_gnt[1];
  assign m0_gnt    = w_gnt[0];
  assign m1_gnt    = w_gnt[1];

  assign w_we      = w_sel_m1 ? m1_we    : m0_we;
  assign mem_addr  = w_sel_m1 ? m1_addr  : m0_addr;
  assign mem_wdata = w_sel_m1 ? m1_wdata : m0_wdata;
  assign mem_we    = w_any_gnt & w_we;
  assign mem_re    = w_any_gnt & ~w_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_gnt <= MID_M1;
    end else if (w_any_gnt) begin
      r_last_gnt <= w_arb_id;
    end
  end

  logic             r_tag_vld [RD_LAT];
  logic [MID_W-1:0] r_tag_id  [RD_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_vld[0] <= 1'b0;
      r_tag_id[0]  <= MID_M0;
    end else begin
      r_tag_vld[0] <= mem_re;
      r_tag_id[0]  <= w_arb_id;
    end
  end

  generate
    for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_tag_stage
      always_ff @(posedge clk) begin
        if (rst) begin
          r_tag_vld[gi] <= 1'b0;
          r_tag_id[gi]  <= MID_M0;
        end else begin
          r_tag_vld[gi] <= r_tag_vld[gi-1];
          r_tag_id[gi]  <= r_tag_id[gi-1];
        end
      end
    end
  endgenerate

  logic             w_ret_vld;
  logic [MID_W-1:0] w_ret_id;

  assign w_ret_vld = r_tag_vld[RD_LAT-1] & ~rst;
  assign w_ret_id  = r_tag_id[RD_LAT-1];

  assign m0_rvalid = w_ret_vld & (w_ret_id == MID_M0);
  assign m1_rvalid = w_ret_vld & (w_ret_id == MID_M1);
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Drives three arbiters (RD_LAT 1, 2, 3) with one shared stimulus stream and
// checks grants, RAM strobes and read returns against a queue of expected reads.
module tb_mem_arbiter;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

  logic        w_m0_gnt    [NI];
  logic        w_m0_rvalid [NI];
  logic [31:0] w_m0_rdata  [NI];
  logic        w_m1_gnt    [NI];
  logic        w_m1_rvalid [NI];
  logic [31:0] w_m1_rdata  [NI];
  logic [31:0] w_mem_addr  [NI];
  logic [31:0] w_mem_wdata [NI];
  logic        w_mem_we    [NI];
  logic        w_mem_re    [NI];
  logic [31:0] w_mem_rdata [NI];

  logic [31:0] ram     [NI][256];
  logic [31:0] rpipe   [NI][3];
  logic [31:0] ref_ram [256];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(gi + 1)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (w_m0_gnt[gi]),
        .m0_rvalid (w_m0_rvalid[gi]),
        .m0_rdata  (w_m0_rdata[gi]),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (w_m1_gnt[gi]),
        .m1_rvalid (w_m1_rvalid[gi]),
        .m1_rdata  (w_m1_rdata[gi]),
        .mem_addr  (w_mem_addr[gi]),
        .mem_wdata (w_mem_wdata[gi]),
        .mem_we    (w_mem_we[gi]),
        .mem_re    (w_mem_re[gi]),
        .mem_rdata (w_mem_rdata[gi])
      );
      assign w_mem_rdata[gi] = rpipe[gi][gi];
    end
  endgenerate

  // RAM model per instance: read data appears RD_LAT cycles after the access.
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (w_mem_we[i]) ram[i][w_mem_addr[i][7:0]] <= w_mem_wdata[i];
      rpipe[i][0] <= ram[i][w_mem_addr[i][7:0]];
      rpipe[i][1] <= rpipe[i][0];
      rpipe[i][2] <= rpipe[i][1];
    end
  end

  typedef struct {
    logic        rst;
    logic        r0, w0;
    logic [31:0] a0, d0;
    logic        r1, w1;
    logic [31:0] a1, d1;
    logic        g0, g1;
  } vec_t;

  typedef struct {
    int          due;
    logic        id;
    logic [31:0] data;
  } exp_t;

  vec_t tbl [$];
  exp_t sb  [NI][$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  function automatic vec_t mk(input logic rs,
                              input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                              input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                              input logic g0, input logic g1);
    vec_t v;
    v.rst = rs;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1;
    return v;
  endfunction

  function automatic vec_t idle();
    return mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endfunction

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d cyc=%0d act=%h exp=%h", name, inst, cyc, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    exp_t        e;
    logic [1:0]  exp_rv;
    logic [31:0] exp_rd;
    logic [31:0] act_rd;
    rst = v.rst;
    m0_req = v.r0; m0_we = v.w0; m0_addr = v.a0; m0_wdata = v.d0;
    m1_req = v.r1; m1_we = v.w1; m1_addr = v.a1; m1_wdata = v.d1;
    @(negedge clk);
    $display("cyc=%0d rst=%0b req=%0b%0b we=%0b%0b exp_gnt=%0b%0b", cyc, v.rst, v.r1, v.r0, v.w1, v.w0, v.g1, v.g0);
    if (v.rst) begin
      for (int i = 0; i < NI; i++) sb[i].delete();
    end
    for (int i = 0; i < NI; i++) begin
      exp_rv = 2'b00;
      exp_rd = 32'h0;
      if (sb[i].size() > 0 && sb[i][0].due == cyc) begin
        e      = sb[i].pop_front();
        exp_rv = e.id ? 2'b10 : 2'b01;
        exp_rd = e.data;
      end
      chk("rvalid", i, 32'({w_m1_rvalid[i], w_m0_rvalid[i]}), 32'(exp_rv));
      if (exp_rv != 2'b00) begin
        act_rd = exp_rv[1] ? w_m1_rdata[i] : w_m0_rdata[i];
        chk("rdata", i, act_rd, exp_rd);
      end
      chk("gnt", i, 32'({w_m1_gnt[i], w_m0_gnt[i]}), 32'({v.g1, v.g0}));
      chk("mem_we", i, 32'(w_mem_we[i]), 32'((v.g0 & v.w0) | (v.g1 & v.w1)));
      chk("mem_re", i, 32'(w_mem_re[i]), 32'((v.g0 & ~v.w0) | (v.g1 & ~v.w1)));
      chk("mem_addr", i, w_mem_addr[i], v.g1 ? v.a1 : v.a0);
      if (v.g0 | v.g1) chk("mem_wdata", i, w_mem_wdata[i], v.g1 ? v.d1 : v.d0);
    end
    if (v.g0 && !v.w0) for (int i = 0; i < NI; i++) sb[i].push_back('{cyc + i + 1, 1'b0, ref_ram[v.a0[7:0]]});
    if (v.g1 && !v.w1) for (int i = 0; i < NI; i++) sb[i].push_back('{cyc + i + 1, 1'b1, ref_ram[v.a1[7:0]]});
    if (v.g0 && v.w0) ref_ram[v.a0[7:0]] = v.d0;
    if (v.g1 && v.w1) ref_ram[v.a1[7:0]] = v.d1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idles(input int n);
    for (int k = 0; k < n; k++) apply(idle());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d act=timeout exp=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < NI; i++)
      for (int j = 0; j < 256; j++) ram[i][j] = 32'hC0DE_0000 + 32'(j);
    for (int j = 0; j < 256; j++) ref_ram[j] = 32'hC0DE_0000 + 32'(j);

    // Reset with both masters requesting: nothing may be granted.
    tbl.push_back(mk(1, 1,0,32'h10,0, 1,0,32'h20,0, 0,0));
    tbl.push_back(mk(1, 1,0,32'h10,0, 1,0,32'h20,0, 0,0));
    // First tie after reset goes to m0, then m1.
    tbl.push_back(mk(0, 1,0,32'h10,0, 1,0,32'h20,0, 1,0));
    tbl.push_back(mk(0, 0,0,32'h10,0, 1,0,32'h20,0, 0,1));
    tbl.push_back(idle());
    tbl.push_back(idle());
    // Continuous contention alternates.
    for (int k = 0; k < 6; k++)
      tbl.push_back(mk(0, 1,0,32'h30 + 32'(k),0, 1,0,32'h60 + 32'(k),0, (k % 2) == 0, (k % 2) == 1));
    tbl.push_back(idle());
    tbl.push_back(idle());
    // m1 writes, m0 reads it back.
    tbl.push_back(mk(0, 0,0,32'h0,0, 1,1,32'h40,32'hDEADBEEF, 0,1));
    tbl.push_back(mk(0, 1,0,32'h40,0, 0,0,32'h0,0, 1,0));
    tbl.push_back(idle());
    tbl.push_back(idle());
    // Alternating single-requester reads m0, m1, m0.
    tbl.push_back(mk(0, 1,0,32'h05,0, 0,0,32'h0,0, 1,0));
    tbl.push_back(mk(0, 0,0,32'h0,0, 1,0,32'h06,0, 0,1));
    tbl.push_back(mk(0, 1,0,32'h07,0, 0,0,32'h0,0, 1,0));
    for (int k = 0; k < 4; k++) tbl.push_back(idle());
    // Pending m0 write loses the tie, then lands, then m1 reads it.
    tbl.push_back(mk(0, 1,1,32'h50,32'h12345678, 1,0,32'h51,0, 0,1));
    tbl.push_back(mk(0, 1,1,32'h50,32'h12345678, 0,0,32'h0,0, 1,0));
    tbl.push_back(mk(0, 0,0,32'h0,0, 1,0,32'h50,0, 0,1));
    for (int k = 0; k < 4; k++) tbl.push_back(idle());

    foreach (tbl[n]) apply(tbl[n]);

    // Reset one cycle after an m1 read grant: that read never returns.
    apply(mk(0, 0,0,32'h0,0, 1,0,32'h22,0, 0,1));
    apply(mk(1, 1,0,32'h11,0, 1,0,32'h21,0, 0,0));
    apply(mk(0, 1,0,32'h11,0, 1,0,32'h21,0, 1,0));
    apply(mk(0, 0,0,32'h0,0, 1,0,32'h21,0, 0,1));
    idles(4);

    // Reset after an m0 grant restores last_gnt=m1, so the tie still goes to m0.
    apply(mk(0, 1,0,32'h12,0, 0,0,32'h0,0, 1,0));
    apply(mk(1, 1,0,32'h13,0, 1,0,32'h23,0, 0,0));
    apply(mk(0, 1,0,32'h13,0, 1,0,32'h23,0, 1,0));
    apply(mk(0, 0,0,32'h0,0, 1,0,32'h23,0, 0,1));
    idles(4);

    // Long idle keeps last_gnt: after an m1 grant the next tie goes to m0.
    apply(mk(0, 0,0,32'h0,0, 1,0,32'h33,0, 0,1));
    idles(10);
    apply(mk(0, 1,0,32'h34,0, 1,0,32'h35,0, 1,0));
    apply(mk(0, 0,0,32'h0,0, 1,0,32'h35,0, 0,1));
    idles(5);

    for (int i = 0; i < NI; i++) chk("sb_empty", i, 32'(sb[i].size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
